// File: rtl/qc_row_accumulator.sv
// rtl/qc_row_accumulator.sv - XOR row accumulator behind a fixed-latency circular shifter
// Optional sticky protocol-error reporting is enabled by defining QC_ROW_ACC_ERR_EN.
module qc_row_accumulator #(
    parameter int MAXZ    = 81,
    parameter int LATENCY = $clog2(MAXZ),
    parameter int ROW_W   = 4
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             blk_valid_i,
    input  logic             blk_first_i,
    input  logic             blk_last_i,
    input  logic [ROW_W-1:0] blk_row_i,
    output logic             blk_ready_o,
    input  logic [MAXZ-1:0]  shf_data_i,
    output logic             acc_valid_o,
    input  logic             acc_ready_i,
    output logic [MAXZ-1:0]  acc_data_o,
    output logic [ROW_W-1:0] acc_row_o,
    output logic             err_o
);

    typedef struct packed {
        logic             valid;
        logic             first;
        logic             last;
        logic [ROW_W-1:0] row;
    } tag_t;

    typedef enum logic {IDLE, ACCUM} state_t;

    // Tag delay line matching the shifter pipeline depth
    tag_t dl [LATENCY];
    tag_t d_tag;

    for (genvar i = 0; i < LATENCY; i++) begin : g_dl
        if (i == 0) begin : g_head
            always_ff @(posedge CLK) begin
                if (!rst_n) dl[0] <= '0;
                else        dl[0] <= {blk_valid_i, blk_first_i, blk_last_i, blk_row_i};
            end
        end else begin : g_tail
            always_ff @(posedge CLK) begin
                if (!rst_n) dl[i] <= '0;
                else        dl[i] <= dl[i-1];
            end
        end
    end

    assign d_tag = dl[LATENCY-1];

    state_t           state_q, state_d;
    logic [MAXZ-1:0]  acc_q, acc_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             push;
    logic [MAXZ-1:0]  push_data;
    logic [ROW_W-1:0] push_row;

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        row_d     = row_q;
        push      = 1'b0;
        push_data = acc_q ^ shf_data_i;
        push_row  = row_q;
        case (state_q)
            IDLE: begin
                if (d_tag.valid && d_tag.first) begin
                    acc_d = shf_data_i;
                    row_d = d_tag.row;
                    if (d_tag.last) begin
                        push      = 1'b1;
                        push_data = shf_data_i;
                        push_row  = d_tag.row;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (d_tag.valid) begin
                    if (d_tag.first) begin
                        // A new row abandons the partial one
                        acc_d = shf_data_i;
                        row_d = d_tag.row;
                        if (d_tag.last) begin
                            push      = 1'b1;
                            push_data = shf_data_i;
                            push_row  = d_tag.row;
                            state_d   = IDLE;
                        end
                    end else if (d_tag.last) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        acc_d = acc_q ^ shf_data_i;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Two-entry result FIFO
    logic [MAXZ-1:0]  fifo_data [2];
    logic [ROW_W-1:0] fifo_row  [2];
    logic             wr_ptr, rd_ptr;
    logic [1:0]       occ;
    logic             pop, full, push_ok;

    assign pop     = acc_valid_o & acc_ready_i;
    assign full    = (occ == 2'd2);
    assign push_ok = push & (~full | pop);

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_row[i]  <= '0;
            end
        end else begin
            if (push_ok) begin
                fifo_data[wr_ptr] <= push_data;
                fifo_row[wr_ptr]  <= push_row;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push_ok} - {1'b0, pop};
        end
    end

    assign acc_valid_o = (occ != 2'd0);
    assign acc_data_o  = fifo_data[rd_ptr];
    assign acc_row_o   = fifo_row[rd_ptr];

    // Rows admitted upstream but not yet pushed into the FIFO
    logic [2:0] inflight_q;
    logic [3:0] budget;
    logic       inc, dec;

    assign inc = blk_valid_i & blk_first_i & blk_ready_o;
    assign dec = push & (inflight_q != 3'd0);

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            inflight_q <= 3'd0;
        end else if (inc && !dec && inflight_q != 3'd7) begin
            inflight_q <= inflight_q + 3'd1;
        end else if (dec && !inc) begin
            inflight_q <= inflight_q - 3'd1;
        end
    end

    assign budget      = {1'b0, inflight_q} + {2'b00, occ};
    assign blk_ready_o = (budget < 4'd2);

`ifdef QC_ROW_ACC_ERR_EN
    logic err_q, err_evt;

    always_comb begin
        err_evt = (d_tag.valid && d_tag.first && state_q == ACCUM) ||
                  (d_tag.valid && !d_tag.first && state_q == IDLE) ||
                  (push && full && !pop);
    end

    always_ff @(posedge CLK) begin
        if (!rst_n)       err_q <= 1'b0;
        else if (err_evt) err_q <= 1'b1;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_qc_row_accumulator.sv
// tb/tb_qc_row_accumulator.sv - randomized bench for qc_row_accumulator against a row-level model
module tb_qc_row_accumulator;
    localparam int MAXZ  = 81;
    localparam int LAT   = 7;
    localparam int ROW_W = 4;
`ifdef QC_ROW_ACC_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             rst_n;
    logic             blk_valid_i, blk_first_i, blk_last_i;
    logic [ROW_W-1:0] blk_row_i;
    logic             blk_ready_o;
    logic [MAXZ-1:0]  shf_data_i;
    logic             acc_valid_o, acc_ready_i;
    logic [MAXZ-1:0]  acc_data_o;
    logic [ROW_W-1:0] acc_row_o;
    logic             err_o;

    always #5 CLK = ~CLK;

    qc_row_accumulator #(.MAXZ(MAXZ), .LATENCY(LAT), .ROW_W(ROW_W)) dut (
        .CLK(CLK), .rst_n(rst_n),
        .blk_valid_i(blk_valid_i), .blk_first_i(blk_first_i), .blk_last_i(blk_last_i),
        .blk_row_i(blk_row_i), .blk_ready_o(blk_ready_o), .shf_data_i(shf_data_i),
        .acc_valid_o(acc_valid_o), .acc_ready_i(acc_ready_i), .acc_data_o(acc_data_o),
        .acc_row_o(acc_row_o), .err_o(err_o)
    );

    typedef struct {
        logic [MAXZ-1:0]  data;
        logic [ROW_W-1:0] row;
        int               t;
    } exp_t;

    exp_t             exp_q [$];
    logic [MAXZ-1:0]  pipe [LAT];
    int               cyc, started, popped, err_at, errors, checks, rdy_mode;
    bit               open;
    logic [MAXZ-1:0]  m_acc;
    logic [ROW_W-1:0] m_row;

    function automatic logic [MAXZ-1:0] rnd_data();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[MAXZ-1:0];
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        started = 0;
        popped  = 0;
        open    = 1'b0;
        err_at  = 1 << 30;
    endtask

    // One clock: drive inputs, check registered outputs, then advance the row model
    task automatic step(input bit v, input bit f, input bit l,
                        input logic [ROW_W-1:0] row, input logic [MAXZ-1:0] data);
        bit rdy, ev, er, ee;
        @(negedge CLK);
        cyc++;
        rdy = (rdy_mode == 2) ? ($urandom_range(0, 1) == 1) : (rdy_mode == 1);
        shf_data_i = pipe[LAT-1];
        for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0]     = v ? data : rnd_data();
        blk_valid_i = v;
        blk_first_i = f;
        blk_last_i  = l;
        blk_row_i   = v ? row : ROW_W'($urandom);
        acc_ready_i = rdy;

        ev = (exp_q.size() > 0) && (exp_q[0].t <= cyc);
        er = (started - popped) < 2;
        ee = ERR_EN && (err_at <= cyc);
        check("acc_valid", 128'(acc_valid_o), 128'(ev));
        check("blk_ready", 128'(blk_ready_o), 128'(er));
        check("err", 128'(err_o), 128'(ee));
        if (ev) begin
            check("acc_data", 128'(acc_data_o), 128'(exp_q[0].data));
            check("acc_row", 128'(acc_row_o), 128'(exp_q[0].row));
            if (rdy) begin
                void'(exp_q.pop_front());
                popped++;
            end
        end

        if (v) begin
            if (f) begin
                if (er) started++;
                if (open && err_at > cyc + LAT + 1) err_at = cyc + LAT + 1;
                open  = 1'b1;
                m_acc = data;
                m_row = row;
            end else if (!open) begin
                if (err_at > cyc + LAT + 1) err_at = cyc + LAT + 1;
            end else begin
                m_acc = m_acc ^ data;
            end
            if (l && open) begin
                exp_q.push_back('{data: m_acc, row: m_row, t: cyc + LAT + 1});
                open = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        cyc++;
        rst_n       = 1'b0;
        blk_valid_i = 1'b0;
        acc_ready_i = 1'b0;
        @(negedge CLK);
        cyc++;
        rst_n = 1'b1;
        model_reset();
        check("rst_acc_valid", 128'(acc_valid_o), 128'(0));
        check("rst_blk_ready", 128'(blk_ready_o), 128'(1));
        check("rst_err", 128'(err_o), 128'(0));
        check("rst_acc_data", 128'(acc_data_o), 128'(0));
        check("rst_acc_row", 128'(acc_row_o), 128'(0));
    endtask

    task automatic send_row(input int len, input int gap_max, input logic [ROW_W-1:0] row);
        int w;
        w = 0;
        while (!((started - popped) < 2) && w < 300) begin
            idle(1);
            w++;
        end
        if (w >= 300) begin
            checks++;
            errors++;
            $display("FAIL ready_wait cycle=%0d got=timeout expected=ready", cyc);
        end
        for (int b = 0; b < len; b++) begin
            step(1'b1, b == 0, b == len - 1, row, rnd_data());
            if (b != len - 1) idle($urandom_range(0, gap_max));
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() > 0 && w < 100) begin
            idle(1);
            w++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain cycle=%0d got=%0d_pending expected=0", cyc, exp_q.size());
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        blk_valid_i = 1'b0;
        blk_first_i = 1'b0;
        blk_last_i  = 1'b0;
        blk_row_i   = '0;
        shf_data_i  = '0;
        acc_ready_i = 1'b0;
        cyc         = 0;
        errors      = 0;
        checks      = 0;
        rdy_mode    = 1;
        for (int i = 0; i < LAT; i++) pipe[i] = '0;
        model_reset();
        do_reset();

        // One-block row, output expected LAT+1 cycles later
        step(1'b1, 1'b1, 1'b1, 4'd3, 81'h1);
        idle(10);

        // Three-block row cancelling to zero
        step(1'b1, 1'b1, 1'b0, 4'd5, 81'hF0);
        step(1'b1, 1'b0, 1'b0, 4'd5, 81'h0F);
        step(1'b1, 1'b0, 1'b1, 4'd5, 81'hFF);
        drain();

        // Back-pressure: two rows fill the budget, third waits for a pop
        rdy_mode = 0;
        step(1'b1, 1'b1, 1'b1, 4'd1, rnd_data());
        step(1'b1, 1'b1, 1'b1, 4'd2, rnd_data());
        idle(15);
        check("stall_blk_ready", 128'(blk_ready_o), 128'(0));
        rdy_mode = 1;
        send_row(1, 0, 4'd4);
        drain();

        // Randomized rows with random back-pressure
        rdy_mode = 2;
        for (int r = 0; r < 60; r++) send_row($urandom_range(1, 4), 2, ROW_W'($urandom));
        rdy_mode = 1;
        drain();

        // Orphan non-first beat is dropped
        step(1'b1, 1'b0, 1'b1, 4'd6, rnd_data());
        idle(10);

        // Restart mid-row: only the second row is delivered
        step(1'b1, 1'b1, 1'b0, 4'd7, rnd_data());
        step(1'b1, 1'b0, 1'b0, 4'd7, rnd_data());
        step(1'b1, 1'b1, 1'b0, 4'd8, rnd_data());
        step(1'b1, 1'b0, 1'b1, 4'd8, rnd_data());
        drain();
        idle(5);

        // Reset in the middle of a row discards it
        step(1'b1, 1'b1, 1'b0, 4'd9, rnd_data());
        step(1'b1, 1'b0, 1'b0, 4'd9, rnd_data());
        do_reset();
        idle(12);
        send_row(2, 1, 4'd10);
        drain();
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
